sha256_w_stream_reader: RTL and testbench
=========================================

Name: sha256_w_stream_reader

Overview:
Sequential consumer-side counterpart to the pipelined SHA-256 message-schedule memory. It accepts one 512-bit message block over a valid/ready handshake. It then streams the schedule words W_0..W_(ROUNDS-1), one 32-bit word per accepted beat, to a round-compression engine. W_16 onward are generated on the fly in a 16-word sliding window, so no full 64-word store is kept. It sits between the block padder/loader and the SHA-256 round datapath of the miner.

Parameters:
ROUNDS, 64, number of W words emitted per block; legal range 16..64.

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  asynchronous, active-low reset
blk_valid  input  1  block_in holds a valid 512-bit block
blk_ready  output  1  reader can accept a block this cycle
block_in  input  512  message block; W_0 = [511:480], W_15 = [31:0]
flush  input  1  synchronous abort of the current block, back to IDLE
w_valid  output  1  w_out/w_idx valid
w_ready  input  1  consumer accepts w_out this cycle
w_out  output  32  current schedule word W_t
w_idx  output  6  current index t
w_last  output  1  high with w_valid when t == ROUNDS-1

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE, window words=0, t=0.
  - blk_ready=1; w_valid=0; w_out=0; w_idx=0; w_last=0.
- State IDLE:
  - blk_ready=1, w_valid=0.
  - On blk_valid&blk_ready: win[0..15] <= W_0..W_15 from block_in, t <= 0, state <= STREAM.
- State STREAM:
  - blk_ready=0, w_valid=1.
  - w_out = win[0], w_idx = t, w_last = (t==ROUNDS-1). All are driven from registers; no combinational path from w_ready.
- Beat (w_valid&w_ready), when t < ROUNDS-1:
  - win[k] <= win[k+1] for k=0..14.
  - win[15] <= s1(win[14]) + win[9] + s0(win[1]) + win[0], mod 2^32.
  - t <= t+1.
- Sigma functions:
  - s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- Beat when t == ROUNDS-1: state <= IDLE, t <= 0, window contents are don't-care.
- Back-to-back blocks: blk_ready is only high in IDLE. There is one idle cycle between the last beat of one block and acceptance of the next. Minimum block period is ROUNDS+1 cycles at w_ready=1.
- Backpressure: with w_ready=0, all of w_out, w_idx, w_last and the window hold stable, and w_valid stays 1. w_valid never drops mid-block except on flush or reset.
- Zero-latency generation: the value computed for win[15] at beat t becomes W_(t+16). It is presented at w_out 16 beats later; no extra pipeline cycles are inserted.
- flush:
  - In STREAM: next state is IDLE and w_valid drops the following cycle. flush has priority over a coincident beat; that beat's word counts as consumed.
  - In IDLE: flush is ignored, and a coincident blk_valid is still accepted.
- blk_valid in STREAM is ignored; the producer must hold block_in until blk_ready.
- Asynchronous reset mid-stream: immediate return to the reset values above; the partial block is discarded.
- w_idx width is fixed at 6 bits for every legal ROUNDS.

Test Plan:
- "abc" padded block (W_0=0x61626380, W_1..W_14=0, W_15=0x00000018), w_ready=1 -> observe:
  - t=0..15 equal to block_in words;
  - W_16=0x61626380, W_17=0x000F0000, W_18=0x7DA86405, W_19=0x600003C6;
  - 64 beats, w_last only at w_idx=63, blk_ready high again the next cycle.
- Same block with w_ready toggled pseudo-randomly (~50%) -> identical 64-word sequence versus a reference model; outputs stable on every cycle with w_valid=1 & w_ready=0.
- Two blocks offered back-to-back with blk_valid held high -> second accepted exactly one cycle after the first block's w_last beat; second stream starts at w_idx=0 with correct words.
- flush asserted at w_idx=20 -> w_valid=0 the next cycle, blk_ready=1; a new block then streams correctly from w_idx=0.
- RST pulsed low mid-stream at w_idx=40 -> w_valid=0 and w_idx=0 immediately, without waiting for a clock edge; blk_ready=1 after release.
- ROUNDS=16 build -> exactly 16 beats, equal to block_in words, w_last at w_idx=15.

Source files
------------

// File: rtl/sha256_w_stream_reader.sv
// SHA-256 message-schedule stream reader: accepts a 512-bit block and emits
// W_0..W_(ROUNDS-1), generating W_16+ in a 16-word sliding window.
module sha256_w_stream_reader #(
   parameter int unsigned ROUNDS = 64
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [511:0] block_in,
   input  logic         flush,
   output logic         w_valid,
   input  logic         w_ready,
   output logic [31:0]  w_out,
   output logic [5:0]   w_idx,
   output logic         w_last
);

   localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   state_t      state, state_nx;
   logic [5:0]  t, t_nx;
   logic [31:0] win [16];
   logic [31:0] w_new;
   logic        load, shift;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // W_(t+16) from the window as it stands at beat t
   assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

   always_comb begin
      state_nx = state;
      t_nx     = t;
      load     = 1'b0;
      shift    = 1'b0;
      case (state)
         IDLE: begin
            if (blk_valid) begin
               load     = 1'b1;
               t_nx     = '0;
               state_nx = STREAM;
            end
         end
         STREAM: begin
            // flush wins over a coincident beat; the beat's word is still consumed
            if (flush) begin
               state_nx = IDLE;
               t_nx     = '0;
            end else if (w_ready) begin
               if (t == LAST_IDX) begin
                  state_nx = IDLE;
                  t_nx     = '0;
               end else begin
                  shift = 1'b1;
                  t_nx  = t + 6'd1;
               end
            end
         end
         default: begin
            state_nx = IDLE;
            t_nx     = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
         t     <= '0;
      end else begin
         state <= state_nx;
         t     <= t_nx;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int unsigned k = 0; k < 16; k++) win[k] <= '0;
      end else if (load) begin
         for (int unsigned k = 0; k < 16; k++) win[k] <= block_in[511 - 32*k -: 32];
      end else if (shift) begin
         for (int unsigned k = 0; k < 15; k++) win[k] <= win[k+1];
         win[15] <= w_new;
      end
   end

   assign blk_ready = (state == IDLE);
   assign w_valid   = (state == STREAM);
   assign w_out     = win[0];
   assign w_idx     = t;
   assign w_last    = (state == STREAM) && (t == LAST_IDX);

endmodule

// File: tb/tb_sha256_w_stream_reader.sv
// Directed bench for sha256_w_stream_reader: "abc" block, backpressure,
// back-to-back blocks, flush, async reset, and a ROUNDS=16 build.
module tb_sha256_w_stream_reader;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic         blk_valid = 1'b0, flush = 1'b0, w_ready = 1'b0;
   logic [511:0] block_in = '0;
   logic         blk_ready, w_valid, w_last;
   logic [31:0]  w_out;
   logic [5:0]   w_idx;

   logic         blk_valid16 = 1'b0, w_ready16 = 1'b0;
   logic [511:0] block_in16 = '0;
   logic         blk_ready16, w_valid16, w_last16;
   logic [31:0]  w_out16;
   logic [5:0]   w_idx16;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0]  mw  [64];
   logic [31:0]  cap [64];
   logic [511:0] abc_blk, blk_b;

   always #5 CLK = ~CLK;

   sha256_w_stream_reader #(.ROUNDS(64)) dut (
      .CLK(CLK), .RST(RST), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .block_in(block_in), .flush(flush), .w_valid(w_valid), .w_ready(w_ready),
      .w_out(w_out), .w_idx(w_idx), .w_last(w_last));

   sha256_w_stream_reader #(.ROUNDS(16)) dut16 (
      .CLK(CLK), .RST(RST), .blk_valid(blk_valid16), .blk_ready(blk_ready16),
      .block_in(block_in16), .flush(1'b0), .w_valid(w_valid16), .w_ready(w_ready16),
      .w_out(w_out16), .w_idx(w_idx16), .w_last(w_last16));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic gen_model(input logic [511:0] blk);
      for (int i = 0; i < 16; i++) mw[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++)
         mw[i] = (rr(mw[i-2], 17) ^ rr(mw[i-2], 19) ^ (mw[i-2] >> 10)) + mw[i-7]
               + (rr(mw[i-15], 7) ^ rr(mw[i-15], 18) ^ (mw[i-15] >> 3)) + mw[i-16];
   endtask

   // Called at a negedge in IDLE; returns at the negedge showing w_idx=0.
   task automatic load(input logic [511:0] blk, input logic with_flush);
      block_in  = blk;
      blk_valid = 1'b1;
      flush     = with_flush;
      check("load_rdy", {31'b0, blk_ready}, 32'd1);
      @(negedge CLK);
      blk_valid = 1'b0;
      flush     = 1'b0;
   endtask

   // Consumes n beats starting at w_idx=0; ends at the negedge after the n-th beat.
   task automatic stream(input logic [511:0] blk, input int n, input bit rnd);
      int k = 0;
      int cyc = 0;
      bit r;
      gen_model(blk);
      while (k < n) begin
         if (cyc > 1000) begin
            check("stream_timeout", k, n);
            break;
         end
         check("valid", {31'b0, w_valid}, 32'd1);
         check("idx", {26'b0, w_idx}, k);
         check("word", w_out, mw[k]);
         check("last", {31'b0, w_last}, {31'b0, k == 63});
         cap[k] = w_out;
         r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         w_ready = r;
         @(negedge CLK);
         if (r) k++;
         cyc++;
      end
      w_ready = 1'b0;
   endtask

   initial begin
      abc_blk = {32'h61626380, 448'b0, 32'h00000018};
      for (int i = 0; i < 16; i++) blk_b[511 - 32*i -: 32] = 32'hdeadbeef ^ (32'h01010101 * i);

      #2;
      check("rst_blk_ready", {31'b0, blk_ready}, 32'd1);
      check("rst_w_valid", {31'b0, w_valid}, 32'd0);
      check("rst_w_out", w_out, 32'd0);
      check("rst_w_idx", {26'b0, w_idx}, 32'd0);
      check("rst_w_last", {31'b0, w_last}, 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);

      // "abc" block, full rate
      load(abc_blk, 1'b0);
      stream(abc_blk, 64, 1'b0);
      check("abc_w16", cap[16], 32'h61626380);
      check("abc_w17", cap[17], 32'h000F0000);
      check("abc_w18", cap[18], 32'h7DA86405);
      check("abc_w19", cap[19], 32'h600003C6);
      check("abc_end_rdy", {31'b0, blk_ready}, 32'd1);
      check("abc_end_valid", {31'b0, w_valid}, 32'd0);

      // random backpressure
      load(abc_blk, 1'b0);
      stream(abc_blk, 64, 1'b1);
      check("bp_end_rdy", {31'b0, blk_ready}, 32'd1);

      // back-to-back with blk_valid held high
      block_in  = abc_blk;
      blk_valid = 1'b1;
      @(negedge CLK);
      block_in = blk_b;
      stream(abc_blk, 64, 1'b0);
      check("b2b_gap_rdy", {31'b0, blk_ready}, 32'd1);
      check("b2b_gap_valid", {31'b0, w_valid}, 32'd0);
      @(negedge CLK);
      blk_valid = 1'b0;
      stream(blk_b, 64, 1'b0);

      // flush at w_idx=20, coincident with a beat
      load(blk_b, 1'b0);
      stream(blk_b, 20, 1'b0);
      check("flush_at_idx", {26'b0, w_idx}, 32'd20);
      flush   = 1'b1;
      w_ready = 1'b1;
      @(negedge CLK);
      flush   = 1'b0;
      w_ready = 1'b0;
      check("flush_valid", {31'b0, w_valid}, 32'd0);
      check("flush_rdy", {31'b0, blk_ready}, 32'd1);
      load(abc_blk, 1'b1);   // flush in IDLE must be ignored
      stream(abc_blk, 64, 1'b0);

      // async reset at w_idx=40
      load(blk_b, 1'b0);
      stream(blk_b, 40, 1'b0);
      #2 RST = 1'b0;
      #1;
      check("arst_valid", {31'b0, w_valid}, 32'd0);
      check("arst_idx", {26'b0, w_idx}, 32'd0);
      check("arst_last", {31'b0, w_last}, 32'd0);
      RST = 1'b1;
      @(negedge CLK);
      check("arst_rdy", {31'b0, blk_ready}, 32'd1);
      check("arst_valid_after", {31'b0, w_valid}, 32'd0);

      // ROUNDS=16 build
      block_in16  = blk_b;
      blk_valid16 = 1'b1;
      @(negedge CLK);
      blk_valid16 = 1'b0;
      w_ready16   = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("r16_valid", {31'b0, w_valid16}, 32'd1);
         check("r16_idx", {26'b0, w_idx16}, i);
         check("r16_word", w_out16, blk_b[511 - 32*i -: 32]);
         check("r16_last", {31'b0, w_last16}, {31'b0, i == 15});
         @(negedge CLK);
      end
      w_ready16 = 1'b0;
      check("r16_end_valid", {31'b0, w_valid16}, 32'd0);
      check("r16_end_rdy", {31'b0, blk_ready16}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
